// File: rtl/latch_bank_hold_sync.sv
// Bank of CHANNELS independent WIDTH-bit enable-capture registers, each with a hold-off window.
// Latency: Q shows captured data 1 cycle after acceptance (0 cycles when TRANSPARENT=1).
// Backpressure: none; E is dropped while FREEZE is set or the channel is HELD.
module latch_bank_hold_sync #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int TRANSPARENT = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS-1:0]       E,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic                      FREEZE,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       VALID,
    output logic [CHANNELS-1:0]       LOCKED
);

    localparam int CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic {
        OPEN = 1'b0,
        HELD = 1'b1
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t             state_q;
        logic [CNT_W-1:0]   cnt_q;
        logic [WIDTH-1:0]   data_q;
        logic               valid_q;
        logic               acc;

        // RST is folded into acc so a transparent Q cannot leak D during reset.
        assign acc = E[i] & ~FREEZE & (state_q == OPEN) & ~RST;

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= OPEN;
                cnt_q   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    OPEN: begin
                        if (acc) begin
                            data_q  <= D[i*WIDTH +: WIDTH];
                            valid_q <= 1'b1;
                            if (HOLD_CYCLES > 0) begin
                                state_q <= HELD;
                                cnt_q   <= CNT_W'(HOLD_INIT);
                            end
                        end
                    end
                    HELD: begin
                        // Counter keeps running under FREEZE; only acceptance is inhibited.
                        if (cnt_q == '0) begin
                            state_q <= OPEN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= OPEN;
                endcase
            end
        end

        assign Q[i*WIDTH +: WIDTH] = ((TRANSPARENT != 0) && acc) ? D[i*WIDTH +: WIDTH] : data_q;
        assign VALID[i]            = valid_q;
        assign LOCKED[i]           = (state_q == HELD);
    end

endmodule
